// File: rtl/dec_rob_queue.sv
// Multi-lane decode-to-ROB dispatch queue: compacts valid decode lanes into a circular FIFO, ROB drains up to WIDTH per cycle.
// Latency: 1 cycle, no bypass. Backpressure: enq_ready is taken from registered count only, and a whole group is accepted or rejected.
module dec_rob_queue #(
  parameter int INS   = 32,
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           enq_valid,
  input  logic [WIDTH*INS-1:0]       enq_ins,
  input  logic [WIDTH*INS-1:0]       enq_pc,
  output logic                       enq_ready,
  output logic [WIDTH-1:0]           deq_valid,
  output logic [WIDTH*INS-1:0]       deq_ins,
  output logic [WIDTH*INS-1:0]       deq_pc,
  input  logic [$clog2(WIDTH+1)-1:0] deq_num,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [INS-1:0] ins_mem [DEPTH];
  logic [INS-1:0] pc_mem  [DEPTH];
  logic [PW-1:0]  head, tail;

  logic [PW-1:0]  lane_off [WIDTH];
  logic [CW-1:0]  enq_pop;
  logic [CW-1:0]  enq_n;
  logic [CW-1:0]  eff_deq;
  logic           enq_fire;
  logic [PW-1:0]  rd_idx;

  assign enq_ready = (CW'(DEPTH) - count) >= CW'(WIDTH);
  assign enq_fire  = enq_ready && (|enq_valid);
  assign enq_n     = enq_fire ? enq_pop : '0;
  assign eff_deq   = (CW'(deq_num) > count) ? count : CW'(deq_num);
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);

  // Each valid lane lands at tail plus the number of valid lanes below it.
  always_comb begin
    enq_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      lane_off[i] = PW'(enq_pop);
      enq_pop     = enq_pop + CW'(enq_valid[i]);
    end
  end

  always_comb begin
    deq_valid = '0;
    deq_ins   = '0;
    deq_pc    = '0;
    rd_idx    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rd_idx                 = head + PW'(i);
      deq_valid[i]           = count > CW'(i);
      deq_ins[i*INS +: INS]  = ins_mem[rd_idx];
      deq_pc[i*INS +: INS]   = pc_mem[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        ins_mem[k] <= '0;
        pc_mem[k]  <= '0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(eff_deq);
      tail  <= tail + PW'(enq_n);
      count <= count + enq_n - eff_deq;
      for (int i = 0; i < WIDTH; i++) begin
        if (enq_fire && enq_valid[i]) begin
          ins_mem[tail + lane_off[i]] <= enq_ins[i*INS +: INS];
          pc_mem[tail + lane_off[i]]  <= enq_pc[i*INS +: INS];
        end
      end
    end
  end
endmodule

// File: tb/tb_dec_rob_queue.sv
// Directed bench for dec_rob_queue (INS=32, WIDTH=2, DEPTH=8) with hand-computed expectations.
module tb_dec_rob_queue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [1:0]  enq_valid;
  logic [63:0] enq_ins;
  logic [63:0] enq_pc;
  logic        enq_ready;
  logic [1:0]  deq_valid;
  logic [63:0] deq_ins;
  logic [63:0] deq_pc;
  logic [1:0]  deq_num;
  logic [3:0]  count;
  logic        full;
  logic        empty;

  int n_checks = 0;
  int n_errors = 0;

  dec_rob_queue #(.INS(32), .WIDTH(2), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .enq_valid(enq_valid), .enq_ins(enq_ins), .enq_pc(enq_pc), .enq_ready(enq_ready),
    .deq_valid(deq_valid), .deq_ins(deq_ins), .deq_pc(deq_pc), .deq_num(deq_num),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [1:0] v, input logic [31:0] i1, input logic [31:0] i0,
                     input logic [31:0] p1, input logic [31:0] p0);
    enq_valid = v;
    enq_ins   = {i1, i0};
    enq_pc    = {p1, p0};
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; deq_num = 2'd0;
    enq(2'b00, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    tick(); tick();
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_ready", 64'(enq_ready), 64'd1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_deq_valid", 64'(deq_valid), 64'd0);
    check("rst_deq_ins", deq_ins, 64'd0);
    check("rst_deq_pc", deq_pc, 64'd0);
    rst_n = 1'b1;

    // Full two-lane group.
    enq(2'b11, 32'h33, 32'h13, 32'h104, 32'h100);
    tick();
    enq(2'b00, 0, 0, 0, 0);
    check("pair_count", 64'(count), 64'd2);
    check("pair_valid", 64'(deq_valid), 64'd3);
    check("pair_ins", deq_ins, {32'h33, 32'h13});
    check("pair_pc", deq_pc, {32'h104, 32'h100});

    // Asynchronous reset between edges.
    rst_n = 1'b0;
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_empty", 64'(empty), 64'd1);
    check("arst_ins", deq_ins, 64'd0);
    rst_n = 1'b1;

    // Compaction: only lane 1 valid.
    enq(2'b10, 32'hAA, 32'h55, 32'h204, 32'h200);
    tick();
    enq(2'b00, 0, 0, 0, 0);
    check("cmp_count", 64'(count), 64'd1);
    check("cmp_valid", 64'(deq_valid), 64'd1);
    check("cmp_ins0", 64'(deq_ins[31:0]), 64'hAA);
    check("cmp_pc0", 64'(deq_pc[31:0]), 64'h204);
    deq_num = 2'd1;
    tick();
    deq_num = 2'd0;
    check("cmp_drain", 64'(empty), 64'd1);

    // Fill from slot 1 so the queue later wraps from slot 7 to slot 0.
    for (int k = 0; k < 4; k++) begin
      enq(2'b11, 32'h1001 + 32'(2*k), 32'h1000 + 32'(2*k),
          32'h4004 + 32'(8*k), 32'h4000 + 32'(8*k));
      tick();
      if (k == 2) check("fill6_ready", 64'(enq_ready), 64'd1);
    end
    check("fill_count", 64'(count), 64'd8);
    check("fill_full", 64'(full), 64'd1);
    check("fill_ready", 64'(enq_ready), 64'd0);
    enq(2'b11, 32'hDEAD, 32'hBEEF, 0, 0);
    tick();
    enq(2'b00, 0, 0, 0, 0);
    check("drop_count", 64'(count), 64'd8);
    check("drop_ins", deq_ins, {32'h1001, 32'h1000});

    deq_num = 2'd2;
    tick();
    check("deq_count", 64'(count), 64'd6);
    check("deq_ready", 64'(enq_ready), 64'd1);
    check("deq_full", 64'(full), 64'd0);
    check("deq_ins", deq_ins, {32'h1003, 32'h1002});
    tick();
    tick();
    deq_num = 2'd0;
    check("wrap_count", 64'(count), 64'd2);
    check("wrap_ins", deq_ins, {32'h1007, 32'h1006});
    check("wrap_pc", deq_pc, {32'h401C, 32'h4018});

    // Single lane then concurrent enqueue and dequeue.
    enq(2'b01, 0, 32'h2000, 0, 32'h5000);
    tick();
    check("one_count", 64'(count), 64'd3);
    enq(2'b11, 32'h2002, 32'h2001, 32'h5008, 32'h5004);
    deq_num = 2'd2;
    tick();
    deq_num = 2'd0;
    check("conc_count", 64'(count), 64'd3);
    check("conc_ins", deq_ins, {32'h2001, 32'h2000});
    enq(2'b11, 32'h2004, 32'h2003, 0, 0);
    tick();
    enq(2'b01, 0, 32'h2005, 0, 0);
    tick();
    enq(2'b10, 32'h2006, 32'h0, 0, 0);
    tick();
    check("seven_count", 64'(count), 64'd7);
    check("seven_ready", 64'(enq_ready), 64'd0);

    // Conservative rule: a same-cycle dequeue does not admit the group.
    enq(2'b11, 32'hCAFE, 32'hF00D, 0, 0);
    deq_num = 2'd2;
    tick();
    enq(2'b00, 0, 0, 0, 0);
    deq_num = 2'd0;
    check("cons_count", 64'(count), 64'd5);
    check("cons_ins", deq_ins, {32'h2003, 32'h2002});

    // Flush with enqueue and dequeue attempted.
    flush = 1'b1;
    enq(2'b11, 32'hBAD1, 32'hBAD0, 0, 0);
    deq_num = 2'd2;
    tick();
    flush = 1'b0;
    deq_num = 2'd0;
    enq(2'b00, 0, 0, 0, 0);
    check("flush_count", 64'(count), 64'd0);
    check("flush_empty", 64'(empty), 64'd1);
    check("flush_valid", 64'(deq_valid), 64'd0);
    enq(2'b11, 32'h3001, 32'h3000, 32'h6004, 32'h6000);
    tick();
    enq(2'b00, 0, 0, 0, 0);
    check("post_flush_count", 64'(count), 64'd2);
    check("post_flush_ins", deq_ins, {32'h3001, 32'h3000});

    // Saturating dequeue.
    deq_num = 2'd1;
    tick();
    check("sat_pre_count", 64'(count), 64'd1);
    check("sat_pre_ins0", 64'(deq_ins[31:0]), 64'h3001);
    deq_num = 2'd2;
    tick();
    check("sat_count", 64'(count), 64'd0);
    check("sat_empty", 64'(empty), 64'd1);
    tick();
    deq_num = 2'd0;
    check("empty_deq_count", 64'(count), 64'd0);
    check("empty_deq_valid", 64'(deq_valid), 64'd0);
    enq(2'b01, 0, 32'h4000, 0, 32'h7000);
    tick();
    enq(2'b00, 0, 0, 0, 0);
    check("after_sat_count", 64'(count), 64'd1);
    check("after_sat_ins0", 64'(deq_ins[31:0]), 64'h4000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
